dff_sticky_set: RTL and testbench

- Parametrised successor to the single-bit set flip-flop: WIDTH channels of sticky event flags, each set by a synchronised hardware event or a software set, and cleared by write-1-to-clear.
- Each channel has a configurable input synchroniser, an edge/level detect mode, an overflow (missed-event) indicator and a masked interrupt output.
- Sits between raw pad/peripheral signals (e.g. UART line, status strobes) and control/status logic that polls or takes an interrupt.

---
 rtl/dff_sticky_set.sv | 109 ++++++++++
 tb/tb_dff_sticky_set.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dff_sticky_set.sv
// dff_sticky_set: WIDTH independent sticky event flags.
// Each channel passes a raw (possibly asynchronous) input through an optional
// synchroniser and an edge/level detector. The resulting event, or a software
// set, makes the flag sticky until write-1-to-clear. Edge-mode channels also
// report events that arrive while the flag is already pending (overflow).
// irq is the registered OR of the masked flags.
module dff_sticky_set #(
  parameter int                 WIDTH       = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [2*WIDTH-1:0] EDGE_SEL    = {WIDTH{2'b01}},
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_sig,
  input  logic [WIDTH-1:0] set_sw,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] overflow,
  output logic             irq,
  output logic [WIDTH-1:0] sync_q
);

  logic [WIDTH-1:0] s;          // synchronised input (last stage)
  logic [WIDTH-1:0] prev_q;     // s delayed by one cycle, for edge detection
  logic             armed_q;    // first enabled cycle has passed
  logic [WIDTH-1:0] ev;         // per-channel detected event
  logic [WIDTH-1:0] edge_chan;  // 1 where the channel is in an edge mode
  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;
  logic [WIDTH-1:0] ovf_q;
  logic [WIDTH-1:0] ovf_d;
  logic             irq_q;

  // Synchroniser: a plain shift chain, or a straight wire when depth is zero.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in_sig;
    end else begin : g_sync
      logic [WIDTH-1:0] chain_q [SYNC_STAGES];

      // Shift chain runs every cycle regardless of ena; reset flushes it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            chain_q[k] <= '0;
          end
        end else begin
          chain_q[0] <= in_sig;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            chain_q[k] <= chain_q[k-1];
          end
        end
      end

      assign s = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // Per-channel event detector, selected at elaboration time by EDGE_SEL.
  // Events are suppressed until armed so the reset value of prev_q cannot
  // fake an edge on the first enabled cycle.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      localparam logic [1:0] MODE = EDGE_SEL[2*gi +: 2];

      assign edge_chan[gi] = (MODE != 2'b00);
      assign ev[gi] = armed_q & ((MODE == 2'b00) ? s[gi] :
                                 (MODE == 2'b01) ? (s[gi] & ~prev_q[gi]) :
                                 (MODE == 2'b10) ? (~s[gi] & prev_q[gi]) :
                                                   (s[gi] ^ prev_q[gi]));
    end
  endgenerate

  // Set (event or software) wins over a simultaneous clear.
  // Overflow only records hardware events hitting an already pending flag
  // that is not being cleared in the same cycle; level channels never overflow.
  always_comb begin
    flags_d = (flags_q & ~clr) | ev | set_sw;
    ovf_d   = ((ovf_q & ~clr) | (ev & flags_q & ~clr)) & edge_chan;
  end

  // prev tracks s every cycle; flag/overflow/irq/armed only move when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
      flags_q <= RESET_VALUE;
      ovf_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q <= s;
      if (ena) begin
        armed_q <= 1'b1;
        flags_q <= flags_d;
        ovf_q   <= ovf_d;
        irq_q   <= |(flags_d & mask);
      end
    end
  end

  assign flags    = flags_q;
  assign overflow = ovf_q;
  assign irq      = irq_q;
  assign sync_q   = s;

endmodule

// File: tb/tb_dff_sticky_set.sv
// Self-checking bench for dff_sticky_set: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model built on a history of sampled inputs.
module tb_dff_sticky_set;
  localparam int          W  = 8;
  localparam int          S  = 2;
  // ch0 rise, ch1 fall, ch2 rise, ch3 level, ch4 any, ch5 any, ch6 fall, ch7 level
  localparam logic [15:0] ES = 16'h2F19;
  localparam logic [7:0]  RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n, ena, irq;
  logic [W-1:0] in_sig, set_sw, clr, mask, flags, overflow, sync_q;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [W-1:0] hist [S+2];   // hist[k] = in_sig sampled k edges ago
  logic [W-1:0] m_flags, m_ovf, m_sync;
  logic         m_irq, m_armed;

  dff_sticky_set #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_SEL(ES), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_sig(in_sig), .set_sw(set_sw),
    .clr(clr), .mask(mask), .flags(flags), .overflow(overflow), .irq(irq),
    .sync_q(sync_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the value seen by the detector at this edge is the
  // input sampled S edges ago; the previous value is the one S+1 edges ago.
  task automatic model_edge();
    logic [W-1:0] sv, pv, evv, nf, no;
    if (!rst_n) begin
      for (int k = 0; k < S + 2; k++) hist[k] = '0;
      m_flags = RV; m_ovf = '0; m_irq = 1'b0; m_armed = 1'b0;
    end else begin
      sv = hist[S];
      pv = hist[S+1];
      if (ena) begin
        evv = '0;
        for (int c = 0; c < W; c++) begin
          logic [1:0] md;
          md = ES[2*c +: 2];
          if (m_armed) begin
            case (md)
              2'b00: evv[c] = sv[c];
              2'b01: evv[c] = sv[c] && !pv[c];
              2'b10: evv[c] = !sv[c] && pv[c];
              default: evv[c] = sv[c] != pv[c];
            endcase
          end
        end
        nf = '0; no = '0;
        for (int c = 0; c < W; c++) begin
          nf[c] = evv[c] || set_sw[c] || (m_flags[c] && !clr[c]);
          if (ES[2*c +: 2] != 2'b00)
            no[c] = !clr[c] && (m_ovf[c] || (evv[c] && m_flags[c]));
        end
        m_flags = nf;
        m_ovf   = no;
        m_irq   = (nf & mask) != 0;
        m_armed = 1'b1;
      end
      for (int k = S + 1; k > 1; k--) hist[k] = hist[k-1];
      hist[1] = in_sig;
    end
    m_sync = hist[S];
  endtask

  // One clock: update model at the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_flags", 32'(flags), 32'(m_flags));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
    chk("model_irq", 32'(irq), 32'(m_irq));
    chk("model_sync_q", 32'(sync_q), 32'(m_sync));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_sig = '0; set_sw = '0; clr = '0; mask = '0;
    for (int k = 0; k < S + 2; k++) hist[k] = '0;
    steps(3);

    // reset value then masked irq
    rst_n = 1'b1;
    step();
    chk("rst_flags", 32'(flags), 32'h0000_00A5);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    mask = 8'h01;
    step();
    chk("mask_irq", 32'(irq), 32'h1);

    // rising latency on ch0, sticky, then overflow on second edge
    mask = '0; clr = 8'hFF; step(); clr = '0;
    chk("clr_all", 32'(flags), 32'h0);
    in_sig[0] = 1'b1;
    step(); chk("lat_e1", 32'(flags[0]), 32'h0);
    step(); chk("lat_e2", 32'(flags[0]), 32'h0);
    step(); chk("lat_e3", 32'(flags[0]), 32'h1);
    in_sig[0] = 1'b0; steps(4);
    chk("sticky_f0", 32'(flags[0]), 32'h1);
    chk("no_ovf0", 32'(overflow[0]), 32'h0);
    in_sig[0] = 1'b1; steps(3);
    chk("ovf0", 32'(overflow[0]), 32'h1);

    // armed suppression: inputs high through reset, ena held low until settled
    rst_n = 1'b0; ena = 1'b0; in_sig = 8'h03; steps(2);
    rst_n = 1'b1; steps(4);
    ena = 1'b1; clr = 8'h01; step(); clr = '0;
    steps(3);
    chk("armed_f0", 32'(flags[0]), 32'h0);
    chk("armed_f1", 32'(flags[1]), 32'h0);
    in_sig[1] = 1'b0;
    steps(2); chk("fall_e2", 32'(flags[1]), 32'h0);
    step();   chk("fall_e3", 32'(flags[1]), 32'h1);

    // event + clear on a pending flag: flag survives, no overflow
    clr = 8'hFF; step(); clr = '0;
    set_sw = 8'h04; step(); set_sw = '0;
    in_sig[2] = 1'b1; steps(2);
    clr = 8'h04; step(); clr = '0;
    chk("clr_ev_f2", 32'(flags[2]), 32'h1);
    chk("clr_ev_o2", 32'(overflow[2]), 32'h0);

    // clear all, then software set with irq
    clr = 8'hFF; mask = 8'hFF; step(); clr = '0;
    chk("clrall_f", 32'(flags), 32'h0);
    chk("clrall_o", 32'(overflow), 32'h0);
    chk("clrall_i", 32'(irq), 32'h0);
    set_sw = 8'h80; mask = 8'h80; step(); set_sw = '0;
    chk("sw_f", 32'(flags), 32'h80);
    chk("sw_i", 32'(irq), 32'h1);
    chk("sw_o7", 32'(overflow[7]), 32'h0);

    // level channel, then ena=0 freezes everything
    in_sig[3] = 1'b1; steps(3);
    chk("lvl_f3", 32'(flags[3]), 32'h1);
    ena = 1'b0; in_sig[4] = 1'b1; set_sw = 8'hFF; clr = 8'hFF; steps(5);
    chk("frz_f", 32'(flags), 32'h88);
    chk("frz_o", 32'(overflow), 32'h0);
    chk("frz_i", 32'(irq), 32'h1);
    ena = 1'b1; set_sw = '0; clr = 8'h08; step(); clr = '0;
    chk("lvl_reset_f", 32'(flags), 32'h88);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      ena    = ($urandom_range(0, 9) != 0);
      in_sig = in_sig ^ (W'($urandom) & W'($urandom));
      set_sw = W'($urandom) & W'($urandom) & W'($urandom);
      clr    = W'($urandom) & W'($urandom) & W'($urandom);
      if ($urandom_range(0, 15) == 0) mask = W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
